logit_accumulator: RTL and testbench
====================================

Name: logit_accumulator

Overview:
- Sits directly upstream of the argmax classifier stage, at the tail of the int8 8-lane SNN datapath.
- Receives one signed contribution per output neuron (3 classes) per timestep.
- Accumulates these contributions over T_STEPS timesteps with per-lane saturation.
- Presents the final 3 logits as one packed word on a valid/ready handshake that plugs straight into the argmax inputs.

Parameters:
- IN_WIDTH, 8: signed width of each per-timestep contribution.
- DATA_WIDTH, 16: signed width of each accumulated logit. Must equal the argmax DATA_WIDTH.
- T_STEPS, 16: number of input beats per frame. Legal range 1..65535.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  upstream contribution valid.
- i_ready  output  1  block can accept a contribution.
- i_data  input  3*IN_WIDTH  packed signed contributions; class k at bits [(k+1)*IN_WIDTH-1 : k*IN_WIDTH].
- o_valid  output  1  final logits valid.
- o_ready  input  1  downstream (argmax) ready.
- o_logits  output  3*DATA_WIDTH  packed signed logits, same lane order as i_data.
- o_sat  output  1  at least one lane saturated during the frame now being presented.

Behaviour:
- Clock and reset: single clock domain. rst_n is asynchronous and active-low.
- Reset values: state=ACCUM, beat counter=0, all accumulators=0, o_valid=0, o_sat=0, o_logits=0. i_ready=1 from the first clock after reset release.
- FSM states:
  - ACCUM: i_ready=1, o_valid=0.
  - OUTPUT: i_ready=0, o_valid=1.
- Beat acceptance: a beat is accepted when i_valid && i_ready.
- First beat of a frame (counter==0): each accumulator is loaded with sign-extended i_data[k]. Stale values are never added. The sat flag is cleared, then set if this load saturates (possible only when IN_WIDTH > DATA_WIDTH).
- Later beats: acc[k] <= sat(acc[k] + sext(i_data[k])).
  - Sum is computed at DATA_WIDTH+1 bits.
  - Result is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Any clamp sets the sticky sat flag.
- Beat counter: increments on each accepted beat.
  - On the accepted beat where counter == T_STEPS-1: counter goes to 0 and state goes to OUTPUT.
  - That final beat's contribution is included in the logits.
- Latency: o_valid asserts on the cycle after the last beat is accepted.
- OUTPUT state: o_logits and o_sat are driven directly from the accumulator and flag registers and stay stable while o_valid=1 && o_ready=0.
- Output handshake: on o_valid && o_ready the state returns to ACCUM and i_ready rises on the next cycle. There is no frame overlap, so throughput is T_STEPS+1 cycles per frame minimum.
- T_STEPS=1: every accepted beat goes straight to OUTPUT; logits equal the sign-extended inputs.
- Gaps: i_valid low during ACCUM holds the counter and accumulators; idle cycles are legal anywhere in a frame.
- i_valid during OUTPUT is ignored; upstream must hold its data (standard ready/valid).
- Reset mid-frame: partial sums are discarded and the block returns to the reset values above.
- Combinational paths: no combinational path from i_valid to o_valid, or from o_ready to i_ready. Both ready signals are decoded from registered state only.

Decomposition:
- Shared package (snn_pkg):
  - NUM_CLASSES=3.
  - Default widths: INT8_W=8, LOGIT_W=16.
  - Helper function for sign-extension and clamp bounds (SAT_MAX/SAT_MIN derived from width).
- Sub-module sat_accum_lane: one lane with load/add select and sat output. Instantiated NUM_CLASSES times inside logit_accumulator; the FSM and counter live at the top.

Test Plan:
- Basic frame: T_STEPS=4, beats (class0,class1,class2) = (1,2,3) x4, o_ready=1 -> o_valid one cycle after 4th accept; logits (4,8,12); o_sat=0; i_ready back high the following cycle.
- Signed mix: T_STEPS=4, class0 = -128,+127,-1,+2, classes 1/2 = 0 -> logit0 = 0, logits1/2 = 0, o_sat=0; downstream argmax picks class 0 on the tie.
- Saturation: DATA_WIDTH=8, T_STEPS=3, class1 = +127 each beat -> logit1 = 127 (clamped), o_sat=1. Next frame of all zeros -> o_sat=0, logits 0 (no carry-over).
- Backpressure and gaps: random i_valid gaps during the frame; o_ready held low 5 cycles in OUTPUT -> o_logits stable, i_ready=0 throughout, exactly one output per frame, no beats lost.
- Reset mid-frame: rst_n low after 2 of 4 beats, then a fresh 4-beat frame of (1,1,1) -> logits (4,4,4).
- T_STEPS=1: single beat (-5,7,0) -> logits (-5,7,0) next cycle; back-to-back frames with o_ready=1 give one frame per 2 cycles.

Source files
------------

// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared widths, state encoding and saturation helpers for the SNN tail
package snn_pkg;

    localparam int NUM_CLASSES = 3;
    localparam int INT8_W      = 8;
    localparam int LOGIT_W     = 16;

    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_OUTPUT = 1'b1
    } acc_state_e;

    function automatic logic signed [63:0] sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

    function automatic logic signed [63:0] sext(input logic [63:0] value, input int width);
        return $signed(value << (64 - width)) >>> (64 - width);
    endfunction

    // Wide enough that neither a load nor an add can wrap before clamping.
    function automatic int sum_width(input int in_w, input int data_w);
        return ((in_w > data_w) ? in_w : data_w) + 1;
    endfunction

endpackage

// File: rtl/sat_accum_lane.sv
// rtl/sat_accum_lane.sv - one saturating accumulator lane with load/add select and sticky sat flag
module sat_accum_lane
    import snn_pkg::*;
#(
    parameter int IN_WIDTH   = INT8_W,
    parameter int DATA_WIDTH = LOGIT_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en_i,
    input  logic                         load_i,
    input  logic signed [IN_WIDTH-1:0]   din_i,
    output logic signed [DATA_WIDTH-1:0] acc_o,
    output logic                         sat_o
);

    localparam int SUM_W = sum_width(IN_WIDTH, DATA_WIDTH);
    localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'(sat_max(DATA_WIDTH));
    localparam logic signed [SUM_W-1:0] MIN_V = SUM_W'(sat_min(DATA_WIDTH));

    logic signed [SUM_W-1:0]      in_ext;
    logic signed [SUM_W-1:0]      acc_ext;
    logic signed [SUM_W-1:0]      sum;
    logic signed [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                         sat_q, sat_d;
    logic                         clamp;

    always_comb begin
        in_ext  = SUM_W'(sext(64'($unsigned(din_i)), IN_WIDTH));
        acc_ext = SUM_W'(acc_q);
        // The first beat of a frame replaces the stale sum instead of adding to it.
        sum     = load_i ? in_ext : acc_ext + in_ext;
        clamp   = 1'b1;
        if (sum > MAX_V) begin
            acc_d = DATA_WIDTH'(MAX_V);
        end else if (sum < MIN_V) begin
            acc_d = DATA_WIDTH'(MIN_V);
        end else begin
            acc_d = DATA_WIDTH'(sum);
            clamp = 1'b0;
        end
        sat_d = clamp | (sat_q & ~load_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else if (en_i) begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    assign acc_o = acc_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/logit_accumulator.sv
// rtl/logit_accumulator.sv - accumulates per-timestep class contributions into saturated logits
module logit_accumulator
    import snn_pkg::*;
#(
    parameter int IN_WIDTH   = INT8_W,
    parameter int DATA_WIDTH = LOGIT_W,
    parameter int T_STEPS    = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_valid,
    output logic                                i_ready,
    input  logic [NUM_CLASSES*IN_WIDTH-1:0]     i_data,
    output logic                                o_valid,
    input  logic                                o_ready,
    output logic [NUM_CLASSES*DATA_WIDTH-1:0]   o_logits,
    output logic                                o_sat
);

    localparam int CNT_W = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(T_STEPS - 1);

    acc_state_e             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   accept;
    logic                   first_beat;
    logic [NUM_CLASSES-1:0] lane_sat;

    // Both readies come from the state register only, so there is no
    // combinational path across the block in either direction.
    assign i_ready    = (state_q == ST_ACCUM);
    assign o_valid    = (state_q == ST_OUTPUT);
    assign accept     = i_valid && i_ready;
    assign first_beat = (cnt_q == '0);
    assign o_sat      = |lane_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        if (cnt_q == LAST_BEAT) begin
                            cnt_q   <= '0;
                            state_q <= ST_OUTPUT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (o_ready) begin
                        state_q <= ST_ACCUM;
                    end
                end
                default: state_q <= ST_ACCUM;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_lane
        sat_accum_lane #(
            .IN_WIDTH   (IN_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (accept),
            .load_i (first_beat),
            .din_i  (i_data[k*IN_WIDTH +: IN_WIDTH]),
            .acc_o  (o_logits[k*DATA_WIDTH +: DATA_WIDTH]),
            .sat_o  (lane_sat[k])
        );
    end

endmodule

// File: tb/tb_logit_accumulator.sv
// tb/tb_logit_accumulator.sv - self-checking bench for logit_accumulator
module tb_logit_accumulator;

    typedef struct {
        int u;
        int n;
        int b[4][3];
        int e[3];
        bit s;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [3];
    logic        iv    [3];
    logic [23:0] id    [3];
    logic        orr   [3];
    logic        ir    [3];
    logic        ov    [3];
    logic        os    [3];
    logic [47:0] lg    [3];

    logic        ir_a, ov_a, os_a, ir_b, ov_b, os_b, ir_c, ov_c, os_c;
    logic [47:0] lg_a, lg_c;
    logic [23:0] lg_b;

    int   n_cmp;
    int   n_bad;
    int   fb [16][3];
    vec_t tv [8];

    logit_accumulator #(.IN_WIDTH(8), .DATA_WIDTH(16), .T_STEPS(4)) dut_a (
        .clk(clk), .rst_n(rst_n[0]), .i_valid(iv[0]), .i_ready(ir_a), .i_data(id[0]),
        .o_valid(ov_a), .o_ready(orr[0]), .o_logits(lg_a), .o_sat(os_a)
    );
    logit_accumulator #(.IN_WIDTH(8), .DATA_WIDTH(8), .T_STEPS(3)) dut_b (
        .clk(clk), .rst_n(rst_n[1]), .i_valid(iv[1]), .i_ready(ir_b), .i_data(id[1]),
        .o_valid(ov_b), .o_ready(orr[1]), .o_logits(lg_b), .o_sat(os_b)
    );
    logit_accumulator #(.IN_WIDTH(8), .DATA_WIDTH(16), .T_STEPS(1)) dut_c (
        .clk(clk), .rst_n(rst_n[2]), .i_valid(iv[2]), .i_ready(ir_c), .i_data(id[2]),
        .o_valid(ov_c), .o_ready(orr[2]), .o_logits(lg_c), .o_sat(os_c)
    );

    always_comb begin
        ir[0] = ir_a; ir[1] = ir_b; ir[2] = ir_c;
        ov[0] = ov_a; ov[1] = ov_b; ov[2] = ov_c;
        os[0] = os_a; os[1] = os_b; os[2] = os_c;
        lg[0] = lg_a;
        lg[2] = lg_c;
        lg[1] = '0;
        for (int k = 0; k < 3; k++) lg[1][k*16 +: 16] = 16'($signed(lg_b[k*8 +: 8]));
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int lane(input int u, input int k);
        logic [15:0] v;
        v = lg[u][k*16 +: 16];
        return int'($signed(v));
    endfunction

    // Reference: each class is a running sum of its contributions, pinned to
    // the logit range after every beat; any pinning marks the frame saturated.
    function automatic void model(input int n, input int dw, output int e[3], output bit s);
        longint hi, lo, acc;
        hi = (longint'(1) <<< (dw - 1)) - 1;
        lo = -hi - 1;
        s  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            acc = 0;
            for (int i = 0; i < n; i++) begin
                acc += fb[i][k];
                if (acc > hi) begin acc = hi; s = 1'b1; end
                else if (acc < lo) begin acc = lo; s = 1'b1; end
            end
            e[k] = int'(acc);
        end
    endfunction

    task automatic send_beat(input int u, input int i, input int gmax);
        int t;
        t = 0;
        repeat ($urandom_range(0, gmax)) begin @(posedge clk); #1; end
        iv[u] = 1'b1;
        id[u] = {8'(fb[i][2]), 8'(fb[i][1]), 8'(fb[i][0])};
        while (1) begin
            @(negedge clk);
            if (ir[u]) break;
            t++;
            if (t > 50) begin chk("beat_accept", ir[u], 1); break; end
        end
        @(posedge clk); #1;
        iv[u] = 1'b0;
        id[u] = 24'($urandom);
    endtask

    task automatic run_frame(input int u, input int n, input int gmax, input int hold,
                             output int l[3], output bit s);
        int t;
        for (int i = 0; i < n; i++) send_beat(u, i, gmax);
        orr[u] = (hold == 0);
        t = 0;
        while (1) begin
            @(negedge clk);
            if (ov[u]) break;
            t++;
            if (t > 50) break;
        end
        chk("out_latency", t, 0);
        for (int k = 0; k < 3; k++) l[k] = lane(u, k);
        s = os[u];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); @(negedge clk);
            for (int k = 0; k < 3; k++) chk("bp_logit_stable", lane(u, k), l[k]);
            chk("bp_sat_stable", os[u], s);
            chk("bp_i_ready_low", ir[u], 0);
            chk("bp_o_valid_held", ov[u], 1);
            if (h == hold - 1) orr[u] = 1'b1;
        end
        @(posedge clk); #1;
        orr[u] = 1'b0;
        @(negedge clk);
        chk("i_ready_back", ir[u], 1);
        chk("single_output", ov[u], 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int l[3];
        int e[3];
        bit s;
        bit es;
        int cnt;
        n_cmp = 0;
        n_bad = 0;
        for (int u = 0; u < 3; u++) begin
            rst_n[u] = 1'b0; iv[u] = 1'b0; orr[u] = 1'b0; id[u] = '0;
        end

        tv[0] = '{0, 4, '{'{1,2,3},'{1,2,3},'{1,2,3},'{1,2,3}}, '{4,8,12}, 1'b0};
        tv[1] = '{0, 4, '{'{-128,0,0},'{127,0,0},'{-1,0,0},'{2,0,0}}, '{0,0,0}, 1'b0};
        tv[2] = '{0, 4, '{'{127,-128,5},'{127,-128,5},'{127,-128,5},'{127,-128,5}}, '{508,-512,20}, 1'b0};
        tv[3] = '{1, 3, '{'{0,127,0},'{0,127,0},'{0,127,0},'{0,0,0}}, '{0,127,0}, 1'b1};
        tv[4] = '{1, 3, '{'{0,0,0},'{0,0,0},'{0,0,0},'{0,0,0}}, '{0,0,0}, 1'b0};
        tv[5] = '{1, 3, '{'{-128,-100,50},'{-128,-100,50},'{-128,-100,50},'{0,0,0}}, '{-128,-128,127}, 1'b1};
        tv[6] = '{2, 1, '{'{-5,7,0},'{0,0,0},'{0,0,0},'{0,0,0}}, '{-5,7,0}, 1'b0};
        tv[7] = '{2, 1, '{'{127,-128,1},'{0,0,0},'{0,0,0},'{0,0,0}}, '{127,-128,1}, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) rst_n[u] = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk("rst_i_ready", ir[u], 1);
            chk("rst_o_valid", ov[u], 0);
            chk("rst_o_sat", os[u], 0);
            chk("rst_logits", lg[u], 0);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++)
                for (int k = 0; k < 3; k++) fb[j][k] = tv[i].b[j][k];
            run_frame(tv[i].u, tv[i].n, 0, 0, l, s);
            for (int k = 0; k < 3; k++) chk($sformatf("vec%0d_logit%0d", i, k), l[k], tv[i].e[k]);
            chk($sformatf("vec%0d_sat", i), s, tv[i].s);
        end

        // Gaps on the input plus five cycles of downstream stall.
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 3; k++) fb[i][k] = int'($signed(8'($urandom)));
        run_frame(0, 4, 3, 5, l, s);
        model(4, 16, e, es);
        for (int k = 0; k < 3; k++) chk("bp_logit", l[k], e[k]);
        chk("bp_sat", s, es);

        // Reset after two of four beats must discard the partial sums.
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 3; k++) fb[i][k] = 5;
        send_beat(0, 0, 0);
        send_beat(0, 1, 0);
        rst_n[0] = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n[0] = 1'b1;
        @(negedge clk);
        chk("midrst_i_ready", ir[0], 1);
        chk("midrst_o_valid", ov[0], 0);
        chk("midrst_logits", lg[0], 0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 3; k++) fb[i][k] = 1;
        run_frame(0, 4, 0, 0, l, s);
        for (int k = 0; k < 3; k++) chk("midrst_frame_logit", l[k], 4);
        chk("midrst_frame_sat", s, 0);

        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 3; i++)
                for (int k = 0; k < 3; k++) fb[i][k] = int'($signed(8'($urandom)));
            run_frame(1, 3, 2, int'($urandom_range(0, 5)), l, s);
            model(3, 8, e, es);
            for (int k = 0; k < 3; k++) chk($sformatf("rand8_f%0d_logit%0d", f, k), l[k], e[k]);
            chk($sformatf("rand8_f%0d_sat", f), s, es);
        end

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < 3; k++) fb[i][k] = int'($signed(8'($urandom)));
            run_frame(0, 4, 2, int'($urandom_range(0, 3)), l, s);
            model(4, 16, e, es);
            for (int k = 0; k < 3; k++) chk($sformatf("rand16_f%0d_logit%0d", f, k), l[k], e[k]);
            chk($sformatf("rand16_f%0d_sat", f), s, es);
        end

        // Single-step frames back to back: one result every other cycle.
        iv[2]  = 1'b1;
        id[2]  = {8'(9), 8'(-4), 8'(3)};
        orr[2] = 1'b1;
        cnt    = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ov[2]) begin
                cnt++;
                chk("t1_logit0", lane(2, 0), 3);
                chk("t1_logit1", lane(2, 1), -4);
                chk("t1_logit2", lane(2, 2), 9);
            end
        end
        iv[2] = 1'b0;
        @(posedge clk); #1;
        orr[2] = 1'b0;
        chk("t1_throughput", cnt, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
